// File: rtl/clock_pkg.sv
// Shared types and constants for the alarm clock mode sequencer:
// mode codes, field codes, range limits and the entry clamp.
package clock_pkg;

   typedef enum logic [2:0] {
      ST_RUN       = 3'b000,
      ST_SET_TIME  = 3'b101,
      ST_SET_ALARM = 3'b110,
      ST_RING      = 3'b111
   } st_e;

   typedef enum logic [1:0] {
      FLD_HOURS   = 2'b00,
      FLD_MINUTES = 2'b01,
      FLD_SECONDS = 2'b10
   } fld_e;

   localparam logic [5:0] MAX_HOURS  = 6'd23;
   localparam logic [5:0] MAX_MINSEC = 6'd59;

   // Full 6-bit compare before any truncation to the hours width.
   function automatic logic [5:0] clamp(fld_e f, logic [5:0] v);
      logic [5:0] lim;
      lim = (f == FLD_HOURS) ? MAX_HOURS : MAX_MINSEC;
      return (v > lim) ? lim : v;
   endfunction

   function automatic fld_e next_fld(fld_e f);
      fld_e n;
      case (f)
         FLD_HOURS:   n = FLD_MINUTES;
         FLD_MINUTES: n = FLD_SECONDS;
         default:     n = FLD_HOURS;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/alarm_mode_ctrl_if.sv
// Load bus from the mode sequencer to the timekeeping counter:
// one-cycle strobe plus target field and value.
interface alarm_mode_ctrl_if;

   logic       t_load;
   logic [1:0] t_field;
   logic [5:0] t_val;

   modport master (
      output t_load,
      output t_field,
      output t_val
   );

   modport slave (
      input t_load,
      input t_field,
      input t_val
   );

endinterface

// File: rtl/alarm_mode_ctrl_btn_edge.sv
// Registered rising-edge pulse for a debounced button level.
// The previous-level flop resets high so a held button stays quiet.
module btn_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic rise
);

   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b1;
         rise   <= 1'b0;
      end else begin
         prev_q <= level;
         rise   <= level & ~prev_q;
      end
   end

endmodule

// File: rtl/alarm_mode_ctrl.sv
// Alarm clock mode sequencer: button-driven mode/field FSM, alarm
// register commits, time-load strobes and a bounded ring timer.
module alarm_mode_ctrl
   import clock_pkg::*;
#(
   parameter int unsigned RING_SECS = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1hz,
   input  logic       mode_but,
   input  logic       nxt_but,
   input  logic       alarm_en,
   input  logic [5:0] in_time,
   input  logic [4:0] cur_h,
   input  logic [5:0] cur_m,
   input  logic [5:0] cur_s,
   output logic [2:0] state,
   output logic [1:0] field,
   output logic [4:0] a_hours,
   output logic [5:0] a_minutes,
   output logic [5:0] a_seconds,
   output logic       ring,
   alarm_mode_ctrl_if.master tl
);

   localparam int CW = $clog2(RING_SECS + 1);
   localparam logic [CW-1:0] RING_LOAD = CW'(RING_SECS);

   logic mode_r;
   logic nxt_r;

   btn_edge u_mode_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .level (mode_but),
      .rise  (mode_r)
   );

   btn_edge u_nxt_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .level (nxt_but),
      .rise  (nxt_r)
   );

   st_e           st_q, st_d;
   fld_e          fld_q, fld_d;
   logic          tl_q, tl_d;
   logic [1:0]    tf_q, tf_d;
   logic [5:0]    tv_q, tv_d;
   logic [4:0]    ah_q, ah_d;
   logic [5:0]    am_q, am_d;
   logic [5:0]    as_q, as_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [5:0] val;
   logic       match;
   logic       last_fld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= ST_RUN;
         fld_q <= FLD_HOURS;
         tl_q  <= 1'b0;
         tf_q  <= 2'b00;
         tv_q  <= 6'd0;
         ah_q  <= 5'd0;
         am_q  <= 6'd0;
         as_q  <= 6'd0;
         cnt_q <= '0;
      end else begin
         st_q  <= st_d;
         fld_q <= fld_d;
         tl_q  <= tl_d;
         tf_q  <= tf_d;
         tv_q  <= tv_d;
         ah_q  <= ah_d;
         am_q  <= am_d;
         as_q  <= as_d;
         cnt_q <= cnt_d;
      end
   end

   assign val      = clamp(fld_q, in_time);
   assign last_fld = (fld_q == FLD_SECONDS);
   assign match    = tick_1hz & alarm_en &
                     ({cur_h, cur_m, cur_s} == {ah_q, am_q, as_q});

   always_comb begin
      st_d  = st_q;
      fld_d = fld_q;
      tl_d  = 1'b0;
      tf_d  = tf_q;
      tv_d  = tv_q;
      ah_d  = ah_q;
      am_d  = am_q;
      as_d  = as_q;
      cnt_d = cnt_q;

      unique case (st_q)
         ST_RUN: begin
            fld_d = FLD_HOURS;
            if (mode_r) begin
               st_d = ST_SET_TIME;
            end else if (match) begin
               st_d  = ST_RING;
               cnt_d = RING_LOAD;
            end
         end

         ST_SET_TIME: begin
            if (mode_r) begin
               st_d  = ST_SET_ALARM;
               fld_d = FLD_HOURS;
            end else if (nxt_r) begin
               tl_d  = 1'b1;
               tf_d  = fld_q;
               tv_d  = val;
               fld_d = next_fld(fld_q);
               if (last_fld) st_d = ST_RUN;
            end
         end

         ST_SET_ALARM: begin
            if (mode_r) begin
               st_d  = ST_RUN;
               fld_d = FLD_HOURS;
            end else if (nxt_r) begin
               unique case (1'b1)
                  fld_q == FLD_HOURS:   ah_d = val[4:0];
                  fld_q == FLD_MINUTES: am_d = val;
                  default:              as_d = val;
               endcase
               fld_d = next_fld(fld_q);
               if (last_fld) st_d = ST_RUN;
            end
         end

         ST_RING: begin
            fld_d = FLD_HOURS;
            // Any button silences; the edge does nothing else.
            if (mode_r || nxt_r) begin
               st_d  = ST_RUN;
               cnt_d = '0;
            end else if (tick_1hz) begin
               if (cnt_q <= CW'(1)) begin
                  st_d  = ST_RUN;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end

         default: begin
            st_d  = ST_RUN;
            fld_d = FLD_HOURS;
            cnt_d = '0;
         end
      endcase
   end

   assign state      = st_q;
   assign field      = fld_q;
   assign a_hours    = ah_q;
   assign a_minutes  = am_q;
   assign a_seconds  = as_q;
   assign ring       = (st_q == ST_RING);
   assign tl.t_load  = tl_q;
   assign tl.t_field = tf_q;
   assign tl.t_val   = tv_q;

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Table-driven bench for alarm_mode_ctrl with a scoreboard queue
// of expected output snapshots, plus reset corner sequences.
module tb_alarm_mode_ctrl;

   typedef struct {
      logic [2:0] st;
      logic [1:0] fld;
      logic       tl;
      logic [1:0] tf;
      logic [5:0] tv;
      logic [4:0] ah;
      logic [5:0] am;
      logic [5:0] as_;
      logic       rg;
   } exp_t;

   typedef struct {
      logic       m;
      logic       n;
      logic       en;
      logic       tk;
      logic [5:0] in_t;
      logic [4:0] ch;
      logic [5:0] cm;
      logic [5:0] cs;
      exp_t       e;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       mode_but = 1'b0;
   logic       nxt_but = 1'b0;
   logic       alarm_en = 1'b0;
   logic [5:0] in_time = 6'd0;
   logic [4:0] cur_h = 5'd0;
   logic [5:0] cur_m = 6'd0;
   logic [5:0] cur_s = 6'd0;
   logic [2:0] state;
   logic [1:0] field;
   logic [4:0] a_hours;
   logic [5:0] a_minutes;
   logic [5:0] a_seconds;
   logic       ring;

   int checks = 0;
   int errors = 0;

   exp_t sb_q[$];
   vec_t tbl[$];

   alarm_mode_ctrl_if tl_if ();

   alarm_mode_ctrl #(.RING_SECS(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_1hz  (tick_1hz),
      .mode_but  (mode_but),
      .nxt_but   (nxt_but),
      .alarm_en  (alarm_en),
      .in_time   (in_time),
      .cur_h     (cur_h),
      .cur_m     (cur_m),
      .cur_s     (cur_s),
      .state     (state),
      .field     (field),
      .a_hours   (a_hours),
      .a_minutes (a_minutes),
      .a_seconds (a_seconds),
      .ring      (ring),
      .tl        (tl_if)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(int m, int n, int en, int tk, int in_t,
                               int ch, int cm, int cs, int st, int fld,
                               int tl, int tf, int tv, int ah, int am,
                               int as_, int rg);
      vec_t v;
      v.m = 1'(m); v.n = 1'(n); v.en = 1'(en); v.tk = 1'(tk);
      v.in_t = 6'(in_t); v.ch = 5'(ch); v.cm = 6'(cm); v.cs = 6'(cs);
      v.e.st = 3'(st); v.e.fld = 2'(fld); v.e.tl = 1'(tl);
      v.e.tf = 2'(tf); v.e.tv = 6'(tv); v.e.ah = 5'(ah);
      v.e.am = 6'(am); v.e.as_ = 6'(as_); v.e.rg = 1'(rg);
      return v;
   endfunction

   task automatic cmp(input string tag, input string what,
                      input logic [7:0] act, input logic [7:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s %s actual=%0d expected=%0d",
                  tag, what, act, exp_v);
      end
   endtask

   task automatic check(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s scoreboard actual=empty expected=entry", tag);
         return;
      end
      e = sb_q.pop_front();
      cmp(tag, "state",     8'(state),         8'(e.st));
      cmp(tag, "field",     8'(field),         8'(e.fld));
      cmp(tag, "t_load",    8'(tl_if.t_load),  8'(e.tl));
      cmp(tag, "t_field",   8'(tl_if.t_field), 8'(e.tf));
      cmp(tag, "t_val",     8'(tl_if.t_val),   8'(e.tv));
      cmp(tag, "a_hours",   8'(a_hours),       8'(e.ah));
      cmp(tag, "a_minutes", 8'(a_minutes),     8'(e.am));
      cmp(tag, "a_seconds", 8'(a_seconds),     8'(e.as_));
      cmp(tag, "ring",      8'(ring),          8'(e.rg));
   endtask

   // Drive at the falling edge, sample 1 time unit after the next rise.
   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      mode_but = v.m; nxt_but = v.n; alarm_en = v.en;
      tick_1hz = v.tk; in_time = v.in_t;
      cur_h = v.ch; cur_m = v.cm; cur_s = v.cs;
      sb_q.push_back(v.e);
      @(posedge clk);
      #1;
      check(tag);
   endtask

   task automatic do_reset(input logic hold_mode);
      @(negedge clk);
      rst_n = 1'b0;
      mode_but = hold_mode; nxt_but = 1'b0; alarm_en = 1'b0;
      tick_1hz = 1'b0; in_time = 6'd0;
      cur_h = 5'd0; cur_m = 6'd0; cur_s = 6'd0;
      @(negedge clk);
      rst_n = 1'b1;
      sb_q.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0).e);
      check("reset");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Mode held through reset: first release/press is the only edge.
      do_reset(1'b1);
      apply(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0), "held_a");
      apply(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0), "held_b");
      apply(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0), "release");
      apply(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0), "press");
      apply(mk(0,0,0,0,0,0,0,0, 5,0,0,0,0,0,0,0,0), "press_eff");

      do_reset(1'b0);

      // m n en tk in ch cm cs | st fld tl tf tv ah am as rg
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 5,0,0,0,0,0,0,0,0));
      tbl.push_back(mk(0,1,0,0,7,0,0,0, 5,0,0,0,0,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,7,0,0,0, 5,1,1,0,7,0,0,0,0));
      tbl.push_back(mk(0,1,0,0,45,0,0,0, 5,1,0,0,7,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,45,0,0,0, 5,2,1,1,45,0,0,0,0));
      tbl.push_back(mk(0,1,0,0,63,0,0,0, 5,2,0,1,45,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,63,0,0,0, 0,0,1,2,59,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,2,59,0,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,2,59,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 5,0,0,2,59,0,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 5,0,0,2,59,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 6,0,0,2,59,0,0,0,0));
      tbl.push_back(mk(0,1,0,0,30,0,0,0, 6,0,0,2,59,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,30,0,0,0, 6,1,0,2,59,23,0,0,0));
      tbl.push_back(mk(0,1,0,0,5,0,0,0, 6,1,0,2,59,23,0,0,0));
      tbl.push_back(mk(0,0,0,0,5,0,0,0, 6,2,0,2,59,23,5,0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 6,2,0,2,59,23,5,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,2,59,23,5,0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,2,59,23,5,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 5,0,0,2,59,23,5,0,0));
      tbl.push_back(mk(1,1,0,0,10,0,0,0, 5,0,0,2,59,23,5,0,0));
      tbl.push_back(mk(0,0,0,0,10,0,0,0, 6,0,0,2,59,23,5,0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 6,0,0,2,59,23,5,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,2,59,23,5,0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,2,59,23,5,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 5,0,0,2,59,23,5,0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 5,0,0,2,59,23,5,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 6,0,0,2,59,23,5,0,0));
      tbl.push_back(mk(0,1,0,0,6,0,0,0, 6,0,0,2,59,23,5,0,0));
      tbl.push_back(mk(0,0,0,0,6,0,0,0, 6,1,0,2,59,6,5,0,0));
      tbl.push_back(mk(0,1,0,0,30,0,0,0, 6,1,0,2,59,6,5,0,0));
      tbl.push_back(mk(0,0,0,0,30,0,0,0, 6,2,0,2,59,6,30,0,0));
      tbl.push_back(mk(0,1,0,0,0,0,0,0, 6,2,0,2,59,6,30,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,2,59,6,30,0,0));
      tbl.push_back(mk(0,0,0,1,0,6,30,0, 0,0,0,2,59,6,30,0,0));
      tbl.push_back(mk(0,0,1,1,0,6,30,1, 0,0,0,2,59,6,30,0,0));
      tbl.push_back(mk(0,0,1,1,0,6,30,0, 7,0,0,2,59,6,30,0,1));
      tbl.push_back(mk(0,0,1,0,0,6,30,1, 7,0,0,2,59,6,30,0,1));
      tbl.push_back(mk(0,0,1,1,0,6,30,1, 7,0,0,2,59,6,30,0,1));
      tbl.push_back(mk(0,0,1,1,0,6,30,2, 7,0,0,2,59,6,30,0,1));
      tbl.push_back(mk(0,0,1,1,0,6,30,3, 0,0,0,2,59,6,30,0,0));
      tbl.push_back(mk(0,0,1,0,0,6,30,4, 0,0,0,2,59,6,30,0,0));
      tbl.push_back(mk(1,0,1,0,0,6,30,0, 0,0,0,2,59,6,30,0,0));
      tbl.push_back(mk(0,0,1,1,0,6,30,0, 5,0,0,2,59,6,30,0,0));
      tbl.push_back(mk(0,0,1,1,0,6,30,0, 5,0,0,2,59,6,30,0,0));
      tbl.push_back(mk(1,0,1,0,0,6,30,0, 5,0,0,2,59,6,30,0,0));
      tbl.push_back(mk(0,0,1,0,0,6,30,0, 6,0,0,2,59,6,30,0,0));
      tbl.push_back(mk(1,0,1,0,0,6,30,0, 6,0,0,2,59,6,30,0,0));
      tbl.push_back(mk(0,0,1,0,0,6,30,0, 0,0,0,2,59,6,30,0,0));
      tbl.push_back(mk(0,0,1,1,0,6,30,0, 7,0,0,2,59,6,30,0,1));
      tbl.push_back(mk(0,1,1,0,0,6,30,0, 7,0,0,2,59,6,30,0,1));
      tbl.push_back(mk(0,0,1,0,0,6,30,0, 0,0,0,2,59,6,30,0,0));
      tbl.push_back(mk(0,0,1,1,0,6,30,0, 7,0,0,2,59,6,30,0,1));
      tbl.push_back(mk(0,0,1,1,0,6,30,0, 7,0,0,2,59,6,30,0,1));
      tbl.push_back(mk(0,0,1,1,0,6,30,0, 7,0,0,2,59,6,30,0,1));
      tbl.push_back(mk(1,0,1,0,0,6,30,0, 7,0,0,2,59,6,30,0,1));
      tbl.push_back(mk(0,0,1,1,0,6,30,0, 0,0,0,2,59,6,30,0,0));
      tbl.push_back(mk(0,0,1,0,0,6,30,1, 0,0,0,2,59,6,30,0,0));

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("row%0d", i));

      // Async reset mid-SET_ALARM after the hours commit.
      apply(mk(1,0,0,0,0,0,0,0, 0,0,0,2,59,6,30,0,0), "ar_m1");
      apply(mk(0,0,0,0,0,0,0,0, 5,0,0,2,59,6,30,0,0), "ar_m2");
      apply(mk(1,0,0,0,0,0,0,0, 5,0,0,2,59,6,30,0,0), "ar_m3");
      apply(mk(0,0,0,0,0,0,0,0, 6,0,0,2,59,6,30,0,0), "ar_m4");
      apply(mk(0,1,0,0,12,0,0,0, 6,0,0,2,59,6,30,0,0), "ar_n1");
      apply(mk(0,0,0,0,12,0,0,0, 6,1,0,2,59,12,30,0,0), "ar_n2");
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      sb_q.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0).e);
      check("async_rst");
      @(negedge clk);
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alarm_mode_ctrl.md
# alarm_mode_ctrl

Central mode sequencer for the alarm clock. It turns the front-panel buttons into the 3-bit mode code and a field pointer. It owns and commits the alarm-time registers, and emits one-cycle load strobes to the timekeeping counter in set-time mode. In run mode it compares the live time against the alarm once per second and drives the ring output for a bounded duration.

## Interface
Parameters:
- RING_SECS, 60: number of 1 Hz ticks the ring output stays asserted (1..255).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- tick_1hz  in  1  one-cycle pulse, once per second, from the prescaler.
- mode_but  in  1  debounced, synchronised level of the mode button.
- nxt_but  in  1  debounced, synchronised level of the next/commit button.
- alarm_en  in  1  alarm arm switch (level).
- in_time  in  6  value from the entry switches.
- cur_h  in  5  live hours, 0..23.
- cur_m  in  6  live minutes, 0..59.
- cur_s  in  6  live seconds, 0..59.
- state  out  3  mode code: RUN=3'b000, SET_TIME=3'b101, SET_ALARM=3'b110, RING=3'b111.
- field  out  2  field pointer: HOURS=2'b00, MINUTES=2'b01, SECONDS=2'b10.
- t_load  out  1  one-cycle strobe: load t_val into live-time field t_field.
- t_field  out  2  target field for t_load.
- t_val  out  6  clamped value for t_load.
- a_hours  out  5  committed alarm hours.
- a_minutes  out  6  committed alarm minutes.
- a_seconds  out  6  committed alarm seconds.
- ring  out  1  alarm sounding; high exactly while state==RING.

## Operation
- Edge detection:
  - Each button gets a registered previous-level flop; edge = level & ~prev.
  - The prev flops reset to 1, so a button held through reset produces no edge.
- FSM:
  - RUN:
    - mode edge -> SET_TIME, field=HOURS.
    - Otherwise, on tick_1hz with alarm_en=1 and {cur_h,cur_m,cur_s}=={a_hours,a_minutes,a_seconds} -> RING; ring counter loads RING_SECS.
  - SET_TIME:
    - mode edge -> SET_ALARM, field=HOURS.
    - nxt edge -> t_load=1 with t_field=field and t_val=clamp(in_time); then field advances. From SECONDS the FSM returns to RUN with field=HOURS.
  - SET_ALARM:
    - mode edge -> RUN, field=HOURS.
    - nxt edge -> the selected a_* register is written with clamp(in_time); field advances as in SET_TIME. From SECONDS -> RUN.
  - RING:
    - Counter decrements on each tick_1hz; on reaching 0 -> RUN.
    - Any mode or nxt edge -> RUN immediately (silence); the edge has no other effect.
- Clamp rule:
  - Hours: values >23 become 23. Minutes and seconds: values >59 become 59.
  - For hours, in_time[5] is ignored only after the clamp; 6-bit compare first.
- Fields are committed individually. Leaving a set mode mid-sequence keeps the earlier commits and leaves the rest unchanged.
- field is don't-care-free: it is held at HOURS in RUN and RING.

## Timing
- Reset values:
  - state=RUN, field=HOURS, t_load=0, t_field=0, t_val=0.
  - a_hours=0, a_minutes=0, a_seconds=0, ring=0, ring counter=0.
- Latency:
  - A button level first sampled high at edge N produces its state, field, a_* or t_load change at edge N+1.
  - t_load is high for exactly one cycle; t_field and t_val are valid in that same cycle.
- The alarm match is evaluated only in the cycle tick_1hz=1 (registered compare inputs are not required); ring rises one cycle later.
- Simultaneous events, by priority:
  - mode edge and nxt edge in the same cycle: mode wins; no commit, no t_load.
  - mode edge and alarm match in RUN in the same cycle: SET_TIME wins; no ring.
  - In RING, a button edge and the final tick in the same cycle: -> RUN (same result).
- Alarm matches in SET_TIME or SET_ALARM are ignored, not deferred.
- Reset asserted mid-sequence or mid-ring: every output returns to its reset value asynchronously; partially entered alarm values are lost.

## Structure
- Shared package clock_pkg holds:
  - state codes: ST_RUN, ST_SET_TIME, ST_SET_ALARM, ST_RING.
  - field codes: FLD_HOURS, FLD_MINUTES, FLD_SECONDS.
  - MAX_HOURS=23, MAX_MINSEC=59.
- One sub-module, btn_edge (prev flop plus rising-edge pulse, reset-to-1), instantiated twice.
- The ring counter width is derived from RING_SECS.

## Test plan
- Reset with mode_but held high, then release and press once -> no action until the second rising edge; state stays 000, then goes 000->101 one cycle after that edge.
- RUN, mode edge, then three nxt edges with in_time=7, 45, 63 -> t_load pulses with (00,7), (01,45), (10,59); state back to 000 after the third.
- Enter SET_ALARM, commit in_time=30 (hours) -> a_hours=23. Commit in_time=5, then mode edge -> a_minutes=5, a_seconds unchanged at 0, state=000.
- alarm=06:30:00, alarm_en=1, cur time 06:30:00 on a tick, RING_SECS=3 -> ring high one cycle after the tick, low after the third following tick; with alarm_en=0 there is no ring.
- Mode and nxt edges in the same cycle in SET_TIME -> state=110, no t_load. nxt edge during RING -> ring drops next cycle, state=000, a_* unchanged.
- rst_n low mid-SET_ALARM after the hours commit -> a_hours=0 and state=000 immediately, without waiting for a clock.
